arb_mux_4to1: RTL
=================

# arb_mux_4to1

Round-robin arbiter and output register that shares the `mux_4to1` datapath among four requesters. Each requester presents ANCHO-bit data with a request flag. The block selects one requester per accepted transfer, drives the mux select, and holds the selected word in a registered output stage with a valid/ready handshake toward the consumer. It sits between the four data sources and the single downstream consumer.

## Interface
- `ANCHO`, 8, data width of each input and of `out`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  `req[i]` = requester i has valid data (i: 0=a, 1=b, 2=c, 3=d).
- `a`, `b`, `c`, `d`  in  ANCHO  requester data; held stable while the matching `req` is high.
- `gnt`  out  4  one-hot, combinational; `gnt[i]`=1 means the word is taken at this rising edge.
- `out`  out  ANCHO  registered selected word.
- `sel`  out  2  registered index of the requester whose word is in `out`.
- `out_valid`  out  1  `out`/`sel` hold an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid` and `out_ready` are both 1.
- `lock`  in  1  present only with `ARB_LOCK_EN`; requests a burst on the current grant.

## Operation
- Internal state:
  - `ptr` (2 b): last granted index.
  - `out_valid`: FULL/EMPTY flag of the output stage.
- `slot_free = !out_valid || out_ready`.
- Grant rule:
  - When `slot_free` and `req != 0`, grant the first requester with `req` high in the order `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4).
  - Otherwise `gnt` = 0.
- On a grant to index k at an edge:
  - `out` is loaded with the mux output for `sel = k`.
  - `sel` ← k, `out_valid` ← 1, `ptr` ← k.
- Consume without a new grant (`out_valid && out_ready && req == 0`): `out_valid` ← 0. `out` and `sel` keep their last values.
- FULL with `out_ready` = 0:
  - `out`, `sel` and `out_valid` are stable.
  - `gnt` = 0.
  - Requesters wait.
- `out_ready` while `out_valid` = 0 has no effect.
- Consume and load in the same cycle are allowed, giving back-to-back throughput of 1 word/cycle.
- A requester that drops `req` before its grant is simply skipped. There is no penalty and `ptr` is unchanged.

## Timing
- Reset values:
  - `out_valid` = 0, `out` = 0, `sel` = 0, `ptr` = 3 (so index 0 has first priority).
  - `gnt` is forced to 0 during every cycle with `rst` = 1.
- Latency: a grant at edge N makes `out_valid`/`out`/`sel` visible after edge N; the consumer can take the word at edge N+1 at the earliest.
- `gnt` depends only on `req`, `ptr`, `out_valid`, `out_ready` (and lock state). There is no path from data inputs to `gnt`.
- Reset mid-operation: any word in the output stage is discarded and the pointer returns to 3. A requester whose `req` was high during `rst` is not granted until `rst` falls.
- Fairness: with all four requesting continuously, every requester is granted once in every 4 grants.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - A grant to k with `lock` = 1 sets the locked state with owner k.
  - While locked, only k can be granted (if `req[k]` = 1); other requests are ignored.
  - Lock releases when k is granted with `lock` = 0, or when `slot_free` = 1 and `req[k]` = 0.
  - `ptr` still updates to k on every grant, so rotation resumes after the owner.
  - `rst` clears the locked state.
- `ARB_LOCK_EN` undefined: there is no `lock` port and no locked state; the block is pure round-robin as above.

## Test plan
1. Reset: hold `rst` = 1 for 2 cycles with `req` = 4'b1111 → `gnt` = 0, `out_valid` = 0, `out` = 0x00, `sel` = 0. The first grant after release is `gnt` = 4'b0001.
2. Full rotation: a=0x11, b=0x22, c=0x33, d=0x44, `req` = 4'b1111, `out_ready` = 1.
   - `gnt` sequence: 0001, 0010, 0100, 1000, 0001.
   - `out`/`sel` one cycle later: 0x11/0, 0x22/1, 0x33/2, 0x44/3, 0x11/0, with `out_valid` continuously 1.
3. Backpressure: `req` = 4'b0010, b=0x5A, `out_ready` = 0.
   - After the first grant: `out` = 0x5A, `sel` = 1, `out_valid` = 1, held for 5 cycles with `gnt` = 0.
   - Set b=0xA5 and pulse `out_ready` = 1 for 1 cycle → `gnt` = 0010 that cycle, next `out` = 0xA5.
4. Skip and wrap: after a grant to index 1, `req` = 4'b1001 → next grant 1000 (d), then 0001 (a). Then `req` = 0 with `out_ready` = 1 → `out_valid` falls to 0 after one cycle.
5. Reset mid-transfer: `out_valid` = 1 with `out` = 0x33 and `out_ready` = 0; assert `rst` for 1 cycle → `out_valid` = 0, `out` = 0x00, and the next grant with `req` = 4'b1111 is 0001.
6. `ARB_LOCK_EN` only: `req` = 4'b1111, `lock` = 1 at the grant to 0.
   - With `out_ready` = 1, 3 further grants all go to 0001.
   - Drop `lock` → the grant to 0 that cycle releases the lock, and the next grant is 0010.

Source files
------------

// File: rtl/arb_mux_4to1_if.sv
// ---------------------------------------------------------------------------
// arb_mux_4to1_if
// Bundle of the request/data/handshake signals between four requesters, the
// round-robin arbiter, and the single downstream consumer.
//
// Signals:
//   req[3:0]        requester i has valid data (0=a, 1=b, 2=c, 3=d)
//   a, b, c, d      requester data words, ANCHO bits each
//   gnt[3:0]        one-hot grant; the granted word is taken at this edge
//   out             registered selected word
//   sel[1:0]        index of the requester whose word sits in out
//   out_valid       out/sel hold an unconsumed word
//   out_ready       consumer accepts the word when out_valid is also high
//   lock            (only with ARB_LOCK_EN) burst request on the current grant
//
// Modports:
//   master  requester/consumer side (drives req, data, out_ready, lock)
//   slave   arbiter side (drives gnt, out, sel, out_valid)
// ---------------------------------------------------------------------------
interface arb_mux_4to1_if #(
    parameter int ANCHO = 8
);
    logic [3:0]       req;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic [ANCHO-1:0] c;
    logic [ANCHO-1:0] d;
    logic [3:0]       gnt;
    logic [ANCHO-1:0] out;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
`ifdef ARB_LOCK_EN
    logic             lock;
`endif

    modport master (
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output req, a, b, c, d, out_ready,
        input  gnt, out, sel, out_valid
    );

    modport slave (
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  req, a, b, c, d, out_ready,
        output gnt, out, sel, out_valid
    );
endinterface

// File: rtl/arb_mux_4to1.sv
// ---------------------------------------------------------------------------
// arb_mux_4to1
// Round-robin arbiter in front of a 4:1 data mux with a one-entry registered
// output stage. One requester is selected per accepted transfer, its word is
// captured into out, and the consumer takes it through a valid/ready
// handshake. A word can be consumed and the next one loaded in the same
// cycle, so throughput is one word per cycle.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous, active-high reset
//   bus   arb_mux_4to1_if.slave (req, a..d, gnt, out, sel, out_valid,
//         out_ready, and lock when enabled)
//
// Configuration:
//   ARB_LOCK_EN  when defined, adds the lock input: a grant taken with
//                lock=1 keeps ownership on that requester until it is granted
//                with lock=0, or until the slot is free and it stops
//                requesting.
// ---------------------------------------------------------------------------
module arb_mux_4to1 #(
    parameter int ANCHO = 8
) (
    input  logic           clk,
    input  logic           rst,
    arb_mux_4to1_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

    stage_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [ANCHO-1:0] out_q;
    logic [1:0]       sel_q;

    logic             slot_free;
    logic [3:0]       req_eff;
    logic [1:0]       gnt_idx;
    logic             found;
    logic             grant_any;
    logic [3:0]       gnt_vec;
    logic [ANCHO-1:0] mux_out;

`ifdef ARB_LOCK_EN
    logic             locked_q, locked_d;
    logic [1:0]       owner_q, owner_d;
`endif

    // State register for the output stage, the rotation pointer and the
    // lock ownership; everything returns to its idle value on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= 2'd3;
`ifdef ARB_LOCK_EN
            locked_q <= 1'b0;
            owner_q  <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
`ifdef ARB_LOCK_EN
            locked_q <= locked_d;
            owner_q  <= owner_d;
`endif
        end
    end

    // Grant selection. The search walks ptr+1, ptr+2, ptr+3, ptr; walking the
    // offsets from far to near and overwriting leaves the nearest hit, which
    // gives the round-robin priority. Only req, ptr, the stage flag, ready and
    // the lock state feed this path, never the data words.
    always_comb begin
        slot_free = (state_q == EMPTY) || bus.out_ready;
        req_eff   = bus.req;
`ifdef ARB_LOCK_EN
        if (locked_q) begin
            req_eff = bus.req & (4'b0001 << owner_q);
        end
`endif
        gnt_idx = ptr_q;
        found   = 1'b0;
        for (int off = 4; off >= 1; off--) begin
            if (req_eff[ptr_q + 2'(off)]) begin
                gnt_idx = ptr_q + 2'(off);
                found   = 1'b1;
            end
        end
        grant_any = found && slot_free && !rst;
        gnt_vec   = grant_any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    // Next-state logic of the output stage: a grant always fills it (even if
    // the old word is being consumed this same cycle); a consume with no new
    // grant empties it. The pointer only moves on a grant, so a requester
    // that drops req before being served is skipped without side effects.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (grant_any) begin
            state_d = FULL;
            ptr_d   = gnt_idx;
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef ARB_LOCK_EN
    // Lock ownership: each grant re-evaluates lock for the granted index; an
    // owner that stops requesting while the slot could take a word gives the
    // lock up so the others are not starved.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (grant_any) begin
            locked_d = bus.lock;
            owner_d  = gnt_idx;
        end else if (locked_q && slot_free && !bus.req[owner_q]) begin
            locked_d = 1'b0;
        end
    end
`endif

    // Shared 4:1 datapath, steered by the grant index.
    always_comb begin
        mux_out = '0;
        case (gnt_idx)
            2'd0:    mux_out = bus.a;
            2'd1:    mux_out = bus.b;
            2'd2:    mux_out = bus.c;
            default: mux_out = bus.d;
        endcase
    end

    // Output word and its source index are captured only on a grant, so a
    // plain consume leaves the last word visible with out_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= 2'd0;
        end else if (grant_any) begin
            out_q <= mux_out;
            sel_q <= gnt_idx;
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.out       = out_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == FULL);

endmodule
